// File: rtl/addr_scan_pkg.sv
// addr_scan_pkg
//   Shared constants and types for the sequential address scanner.
//   ADDR_W : address width feeding the 6:64 one-hot decoder
//   CNT_W  : transfer-count width, wide enough to hold a full 64-address scan
//   scan_state_t : scanner FSM states
package addr_scan_pkg;

   localparam int ADDR_W = 6;
   localparam int CNT_W  = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } scan_state_t;

endpackage

// File: rtl/scan_counter.sv
// scan_counter
//   Wrapping ADDR_W-bit address counter with a captured end-of-range value.
//   Ports:
//     clk, rst_n  : clock and synchronous active-low reset
//     load        : capture first/last; value takes first
//     first, last : range bounds (inclusive), used only on load
//     enable      : advance value by one, modulo 2**ADDR_W
//     value       : current address
//     at_last     : value equals the captured last address
module scan_counter
   import addr_scan_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] first,
   input  logic [ADDR_W-1:0] last,
   input  logic              enable,
   output logic [ADDR_W-1:0] value,
   output logic              at_last
);

   logic [ADDR_W-1:0] value_reg;
   logic [ADDR_W-1:0] last_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_reg <= '0;
         last_reg  <= '0;
      end else if (load) begin
         value_reg <= first;
         last_reg  <= last;
      end else if (enable) begin
         // Natural overflow of the ADDR_W-bit add gives the 63 -> 0 wrap.
         value_reg <= value_reg + 1'b1;
      end
   end

   assign value   = value_reg;
   assign at_last = (value_reg == last_reg);

endmodule

// File: rtl/addr_scan_seq.sv
// addr_scan_seq
//   Walks the inclusive address range first_i..last_i (modulo 64), presenting
//   one address per valid/ready transfer to a downstream 6:64 decoder.
//   Ports:
//     clk, rst_n       : clock and synchronous active-low reset
//     start_i          : begin a scan (honoured only in IDLE)
//     stop_i           : abort the current scan
//     first_i, last_i  : range bounds, captured on an accepted start
//     addr_o, valid_o  : address to the decoder and its valid flag
//     ready_i          : downstream accepts addr_o
//     busy_o           : scan in progress
//     done_o           : one-cycle pulse after the last address is accepted
//     abort_o          : one-cycle pulse when a scan is aborted
//     count_o          : transfers accepted in the current or most recent scan
module addr_scan_seq
   import addr_scan_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [ADDR_W-1:0] first_i,
   input  logic [ADDR_W-1:0] last_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              abort_o,
   output logic [CNT_W-1:0]  count_o
);

   scan_state_t       state_reg, state_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              valid_reg, done_reg, abort_reg, abort_next;
   logic              load, advance, at_last;
   logic              xfer;

   // valid is high exactly in SCAN, so a transfer needs only state and ready.
   assign xfer = (state_reg == SCAN) && ready_i;

   scan_counter u_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .first   (first_i),
      .last    (last_i),
      .enable  (advance),
      .value   (addr_o),
      .at_last (at_last)
   );

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      abort_next = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      unique case (state_reg)
         IDLE: begin
            // start outranks a simultaneous stop here; stop alone is ignored.
            if (start_i) begin
               load       = 1'b1;
               count_next = '0;
               state_next = SCAN;
            end
         end
         SCAN: begin
            if (xfer) begin
               count_next = count_reg + 1'b1;
            end
            // Accepting the last address finishes the scan even with stop set,
            // so done wins over abort in that case.
            if (xfer && at_last) begin
               state_next = FINISH;
            end else begin
               advance = xfer;
               if (stop_i) begin
                  state_next = IDLE;
                  abort_next = 1'b1;
               end
            end
         end
         FINISH: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output flags are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         count_reg <= '0;
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
         abort_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         valid_reg <= (state_next == SCAN);
         done_reg  <= (state_next == FINISH);
         abort_reg <= abort_next;
      end
   end

   assign valid_o = valid_reg;
   assign busy_o  = valid_reg;
   assign done_o  = done_reg;
   assign abort_o = abort_reg;
   assign count_o = count_reg;

endmodule

// File: tb/tb_addr_scan_seq.sv
// tb_addr_scan_seq
//   Directed self-checking bench for addr_scan_seq. Inputs change 1 time unit
//   after each rising edge; outputs are checked at the same point.
module tb_addr_scan_seq;
   import addr_scan_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start_i, stop_i, ready_i;
   logic [ADDR_W-1:0] first_i, last_i;
   logic [ADDR_W-1:0] addr_o;
   logic              valid_o, busy_o, done_o, abort_o;
   logic [CNT_W-1:0]  count_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   addr_scan_seq dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start_i),
      .stop_i  (stop_i),
      .first_i (first_i),
      .last_i  (last_i),
      .addr_o  (addr_o),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .abort_o (abort_o),
      .count_o (count_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input int cnt);
      chk({tag, " valid"}, 32'(valid_o), 0);
      chk({tag, " busy"},  32'(busy_o),  0);
      chk({tag, " done"},  32'(done_o),  0);
      chk({tag, " abort"}, 32'(abort_o), 0);
      chk({tag, " count"}, 32'(count_o), 32'(cnt));
   endtask

   // Full scan with ready held high; n is the hand-computed range size.
   task automatic run_scan(input int f, input int l, input int n);
      first_i = ADDR_W'(f);
      last_i  = ADDR_W'(l);
      start_i = 1'b1;
      ready_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("scan%0d-%0d addr[%0d]", f, l, i), 32'(addr_o), 32'((f + i) % 64));
         chk($sformatf("scan%0d-%0d valid[%0d]", f, l, i), 32'(valid_o), 1);
         chk($sformatf("scan%0d-%0d count[%0d]", f, l, i), 32'(count_o), 32'(i));
         chk($sformatf("scan%0d-%0d done[%0d]", f, l, i), 32'(done_o), 0);
         step();
      end
      chk($sformatf("scan%0d-%0d done pulse", f, l), 32'(done_o), 1);
      chk($sformatf("scan%0d-%0d valid at done", f, l), 32'(valid_o), 0);
      chk($sformatf("scan%0d-%0d final count", f, l), 32'(count_o), 32'(n));
      step();
      chk_idle($sformatf("scan%0d-%0d after", f, l), n);
      $display("scan first=%0d last=%0d transfers=%0d count=%0d", f, l, n, count_o);
   endtask

   initial begin
      rst_n   = 1'b0;
      start_i = 1'b0;
      stop_i  = 1'b0;
      ready_i = 1'b0;
      first_i = '0;
      last_i  = '0;
      step();
      step();
      chk("reset addr", 32'(addr_o), 0);
      chk_idle("reset", 0);
      rst_n = 1'b1;

      // stop in IDLE is ignored
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      chk_idle("stop in idle", 0);

      run_scan(5, 8, 4);
      run_scan(62, 1, 4);
      run_scan(0, 63, 64);

      // Back-pressure at address 11
      first_i = 6'd10;
      last_i  = 6'd12;
      start_i = 1'b1;
      ready_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("bp addr10", 32'(addr_o), 10);
      chk("bp count cleared", 32'(count_o), 0);
      step();
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp hold addr[%0d]", i), 32'(addr_o), 11);
         chk($sformatf("bp hold valid[%0d]", i), 32'(valid_o), 1);
         chk($sformatf("bp hold count[%0d]", i), 32'(count_o), 1);
         step();
      end
      ready_i = 1'b1;
      chk("bp addr11", 32'(addr_o), 11);
      step();
      chk("bp addr12", 32'(addr_o), 12);
      step();
      chk("bp done", 32'(done_o), 1);
      chk("bp count", 32'(count_o), 3);
      step();
      chk_idle("bp after", 3);
      $display("backpressure scan 10..12 count=%0d", count_o);

      // Abort together with the transfer of address 3
      first_i = 6'd0;
      last_i  = 6'd20;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      step();
      step();
      chk("abort addr3", 32'(addr_o), 3);
      stop_i = 1'b1;
      step();
      stop_i = 1'b0;
      chk("abort pulse", 32'(abort_o), 1);
      chk("abort valid", 32'(valid_o), 0);
      chk("abort busy", 32'(busy_o), 0);
      chk("abort no done", 32'(done_o), 0);
      chk("abort count", 32'(count_o), 4);
      step();
      chk_idle("abort after", 4);
      $display("abort scan 0..20 count=%0d", count_o);

      // Reset mid-scan with ready high
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      step();
      chk("midscan valid before rst", 32'(valid_o), 1);
      rst_n = 1'b0;
      step();
      chk("midscan rst addr", 32'(addr_o), 0);
      chk_idle("midscan rst", 0);
      rst_n = 1'b1;
      step();
      chk_idle("midscan rst stays idle", 0);
      $display("reset mid-scan addr=%0d count=%0d", addr_o, count_o);

      // Single-address scan; start during SCAN/FINISH must not be queued
      first_i = 6'd40;
      last_i  = 6'd40;
      start_i = 1'b1;
      step();
      chk("single addr", 32'(addr_o), 40);
      chk("single valid", 32'(valid_o), 1);
      first_i = 6'd7;
      last_i  = 6'd9;
      step();
      chk("single done", 32'(done_o), 1);
      chk("single count", 32'(count_o), 1);
      step();
      start_i = 1'b0;
      chk_idle("single start ignored", 1);
      step();
      chk_idle("single still idle", 1);
      $display("single scan 40..40 count=%0d", count_o);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/addr_scan_seq.md
# addr_scan_seq

Sequential 6-bit address scanner feeding the 6:64 one-hot decoder. It walks an inclusive address range from `first_i` to `last_i`, wrapping modulo 64, and presents one address per valid/ready transfer. The downstream decoder turns each accepted address into a one-hot select. It also reports completion, abort and a transfer count.

## Interface
- `ADDR_W`, 6, address width; the decoder stage is 6:64.
- `CNT_W`, 7, transfer-count width; holds the value 64.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start_i`  in  1  begin a scan; honoured only in IDLE.
- `stop_i`  in  1  abort the current scan.
- `first_i`  in  ADDR_W  start address; captured on an accepted start.
- `last_i`  in  ADDR_W  final address, inclusive; captured on an accepted start.
- `addr_o`  out  ADDR_W  current address to the decoder.
- `valid_o`  out  1  `addr_o` is valid.
- `ready_i`  in  1  downstream accepts `addr_o`.
- `busy_o`  out  1  high in SCAN.
- `done_o`  out  1  one-cycle pulse after the last address is accepted.
- `abort_o`  out  1  one-cycle pulse when a scan is aborted.
- `count_o`  out  CNT_W  transfers accepted in the current or most recent scan.

## Operation
- FSM states: IDLE, SCAN, FINISH.
- IDLE:
  - `start_i`=1: capture `first_i`/`last_i`, set `addr_o`=first, clear `count_o`, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN:
  - `valid_o`=1 and `busy_o`=1.
  - Transfer occurs when `valid_o` and `ready_i` are both 1.
  - On a transfer, `count_o` increments.
  - If `addr_o`==last on a transfer: go to FINISH. Otherwise `addr_o` = (`addr_o`+1) mod 64, so 63 wraps to 0.
  - No transfer (`ready_i`=0): `addr_o` and `valid_o` hold stable. `valid_o` never drops without a transfer unless the scan is aborted or reset.
- FINISH: `done_o`=1 for exactly one cycle, then go to IDLE.
- Range size: ((last − first) mod 64) + 1 transfers.
  - first==last gives exactly 1 transfer.
  - first=last+1 (mod 64) gives the full 64.
- `stop_i` in SCAN: next cycle IDLE, with `valid_o`=0 and `abort_o`=1 for one cycle. `done_o` does not pulse. `count_o` keeps its value.
- `stop_i` and a transfer in the same cycle: the transfer counts (`count_o` increments), then the scan aborts. If that transfer was the last address, `done_o` takes priority and `abort_o` stays 0.
- `stop_i` in IDLE or FINISH: ignored.
- `start_i` in SCAN or FINISH: ignored; it is not queued.
- `start_i` and `stop_i` together in IDLE: start wins.
- `first_i`/`last_i` changing during a scan: no effect.

## Timing
- Reset (`rst_n`=0 at an edge), including mid-scan:
  - Next cycle state=IDLE.
  - `addr_o`=0, `valid_o`=0, `busy_o`=0, `done_o`=0, `abort_o`=0, `count_o`=0.
  - Any transfer in the reset cycle is discarded.
- Start latency: `start_i` sampled at edge N gives `valid_o`=1 with `addr_o`=first after edge N, i.e. in cycle N+1.
- Throughput: 1 address per cycle while `ready_i`=1.
- `done_o` is high in the cycle after the final transfer. `valid_o`=0 in that cycle.
- Earliest restart: `start_i` sampled in the first IDLE cycle after FINISH. A back-to-back scan therefore has a 2-cycle gap in `valid_o`.
- All outputs are registered; there is no combinational path from `ready_i` to `valid_o` or `addr_o`.

## Structure
- Package `addr_scan_pkg`:
  - `ADDR_W`, `CNT_W` constants.
  - `scan_state_t` enum {IDLE, SCAN, FINISH}.
- One sub-module, `scan_counter`: wrapping ADDR_W-bit counter with load, enable and `at_last` compare.
- The FSM and the counter of accepted transfers live in the top level.
- The 6:64 decoder is instantiated by the parent, not inside this block.

## Test plan
- Reset, then first=5, last=8, `ready_i`=1 -> `addr_o` 5,6,7,8 on consecutive cycles; `done_o` pulses once; `count_o`=4.
- Wrap range: first=62, last=1 -> addresses 62,63,0,1; `count_o`=4.
- Full range: first=0, last=63 -> 64 transfers, then `done_o`; `count_o`=64.
- Back-pressure on first=10, last=12: `ready_i` low for 3 cycles at address 11 -> `addr_o`=11 and `valid_o`=1 held for those 3 cycles; still exactly 3 transfers.
- Abort on first=0, last=20: `stop_i` together with the transfer of address 3 -> `abort_o` pulses once; no `done_o`; `count_o`=4. Then `rst_n`=0 mid-scan -> all outputs 0 the next cycle.
- first==last=40 -> 1 transfer; `done_o` pulses. `start_i` asserted during SCAN is ignored.
